// File: rtl/sram_controller_pkg.sv
// Shared definitions for the CPU-side SRAM controller: state encoding,
// SRAM bus widths and the default byte address of SRAM word 0.
package sram_controller_pkg;

   localparam int SRAM_ADDR_W       = 18;
   localparam int SRAM_DATA_W       = 16;
   localparam int SRAM_WORD_W       = 17;
   localparam int CNT_W             = 4;
   localparam int BASE_ADDR_DEFAULT = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_READ  = 2'd1,
      OP_WRITE = 2'd2
   } op_e;

   // 32-bit word index inside the SRAM window, wrapped to the SRAM size.
   function automatic logic [SRAM_WORD_W-1:0] word_of(input logic [31:0] addr,
                                                      input int          base);
      logic [31:0] off;
      off = addr - 32'(base);
      return off[SRAM_WORD_W+1:2];
   endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit CPU load/store into two 16-bit SRAM accesses (low half,
// then high half), each held for WAIT_CYCLES clocks; ready gates the pipeline.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int BASE_ADDR   = BASE_ADDR_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   write_en,
   input  logic                   read_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [SRAM_DATA_W-1:0] sram_wdata,
   input  logic [SRAM_DATA_W-1:0] sram_rdata,
   output logic                   sram_we_n,
   output logic                   sram_dq_oe,
   output logic [1:0]             dbg_state
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   op_e                    op_q, op_d;
   logic [SRAM_WORD_W-1:0] word_q, word_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [31:0]            rdata_q, rdata_d;
   logic                   last_cyc;

   assign last_cyc = (cnt_q == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_NONE;
         word_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // The request is latched on leaving IDLE so the access ignores later input changes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (write_en || read_en) begin
               state_d = LOW;
               op_d    = write_en ? OP_WRITE : OP_READ;
               word_d  = word_of(address, BASE_ADDR);
               wdata_d = write_data;
            end
         end
         LOW: begin
            if (last_cyc) begin
               state_d = HIGH;
               cnt_d   = '0;
               if (op_q == OP_READ) rdata_d[15:0] = sram_rdata;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         HIGH: begin
            if (last_cyc) begin
               state_d = DONE;
               cnt_d   = '0;
               if (op_q == OP_READ) rdata_d[31:16] = sram_rdata;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
            op_d    = OP_NONE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      ready      = (state_q == DONE) || ((state_q == IDLE) && !read_en && !write_en);
      sram_addr  = '0;
      sram_wdata = '0;
      sram_we_n  = 1'b1;
      sram_dq_oe = 1'b0;
      if ((state_q == LOW) || (state_q == HIGH)) begin
         sram_addr = {word_q, (state_q == HIGH)};
         if (op_q == OP_WRITE) begin
            sram_we_n  = 1'b0;
            sram_dq_oe = 1'b1;
            sram_wdata = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
         end
      end
   end

   assign read_data = rdata_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: two instances (WAIT_CYCLES 2 and 1),
// each with a small behavioural SRAM; load results go through a scoreboard queue.
module tb_sram_controller;
  import sram_controller_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT (WAIT_CYCLES = 2) ----------------
  logic        write_en = 1'b0, read_en = 1'b0;
  logic [31:0] address = '0, write_data = '0, read_data;
  logic        ready, sram_we_n, sram_dq_oe;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic [1:0]  dbg_state;

  sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(1024)) dut (
    .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_we_n(sram_we_n), .sram_dq_oe(sram_dq_oe),
    .dbg_state(dbg_state)
  );

  // ---------------- DUT (WAIT_CYCLES = 1) ----------------
  logic        write_en1 = 1'b0, read_en1 = 1'b0;
  logic [31:0] address1 = '0, write_data1 = '0, read_data1;
  logic        ready1, sram_we_n1, sram_dq_oe1;
  logic [17:0] sram_addr1;
  logic [15:0] sram_wdata1, sram_rdata1;
  logic [1:0]  dbg_state1;

  sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) dut1 (
    .clk(clk), .rst(rst), .write_en(write_en1), .read_en(read_en1),
    .address(address1), .write_data(write_data1), .read_data(read_data1),
    .ready(ready1), .sram_addr(sram_addr1), .sram_wdata(sram_wdata1),
    .sram_rdata(sram_rdata1), .sram_we_n(sram_we_n1), .sram_dq_oe(sram_dq_oe1),
    .dbg_state(dbg_state1)
  );

  // ---------------- SRAM models ----------------
  logic        preload = 1'b1;
  logic [15:0] mem  [0:63];
  logic [15:0] mem1 [0:63];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) begin
        mem[i]  <= 16'h0000;
        mem1[i] <= 16'h0000;
      end
      mem[4]  <= 16'h1234;
      mem[5]  <= 16'hABCD;
      mem1[0] <= 16'h5678;
      mem1[1] <= 16'h9ABC;
    end else begin
      if (!sram_we_n && sram_dq_oe)   mem[sram_addr[5:0]]   <= sram_wdata;
      if (!sram_we_n1 && sram_dq_oe1) mem1[sram_addr1[5:0]] <= sram_wdata1;
    end
  end

  assign sram_rdata  = mem[sram_addr[5:0]];
  assign sram_rdata1 = mem1[sram_addr1[5:0]];

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd_model = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance: request in cycle 0, DONE in cycle 5.
  task automatic access(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] data, input bit drop, input string tag);
    logic [31:0] off;
    logic [16:0] w;
    logic [17:0] a_lo, a_hi;
    logic [31:0] exp;
    bit          hi;
    int          we_low;
    off    = addr - 32'd1024;
    w      = off[18:2];
    a_lo   = {w, 1'b0};
    a_hi   = {w, 1'b1};
    we_low = 0;
    if (!we) exp_q.push_back({mem[a_hi[5:0]], mem[a_lo[5:0]]});
    @(posedge clk); #1;
    write_en = we; read_en = re; address = addr; write_data = data;
    @(negedge clk);
    chk({tag, "_rdy_c0"}, 32'(ready), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (drop && c == 1) begin
        write_en = 1'b0; read_en = 1'b0;
        address = 32'hFFFF_FFF0; write_data = 32'h0BAD_0BAD;
      end
      @(negedge clk);
      hi = (c > 2);
      chk($sformatf("%s_addr_c%0d", tag, c), 32'(sram_addr), 32'({w, hi}));
      chk($sformatf("%s_wen_c%0d", tag, c), 32'(sram_we_n), 32'(!we));
      chk($sformatf("%s_oe_c%0d", tag, c), 32'(sram_dq_oe), 32'(we));
      if (we) chk($sformatf("%s_wd_c%0d", tag, c), 32'(sram_wdata),
                  hi ? 32'(data[31:16]) : 32'(data[15:0]));
      chk($sformatf("%s_rdy_c%0d", tag, c), 32'(ready), 32'd0);
      if (!sram_we_n) we_low++;
    end
    @(posedge clk); #1;
    write_en = 1'b0; read_en = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy_c5"}, 32'(ready), 32'd1);
    chk({tag, "_st_c5"}, 32'(dbg_state), 32'(DONE));
    chk({tag, "_wen_c5"}, 32'(sram_we_n), 32'd1);
    if (we) begin
      chk({tag, "_welow"}, 32'(we_low), 32'd4);
    end else begin
      exp = exp_q.pop_front();
      rd_model = exp;
    end
    chk({tag, "_rdata"}, read_data, rd_model);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_idle_rdy"}, 32'(ready), 32'd1);
    chk({tag, "_idle_st"}, 32'(dbg_state), 32'(IDLE));
    chk({tag, "_idle_wd"}, 32'(sram_wdata), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_st", 32'(dbg_state), 32'(IDLE));
    chk("rst_wen", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_rdata", read_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; preload = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", 32'(ready), 32'd1);
    chk("post_rst_rdy1", 32'(ready1), 32'd1);

    access(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1'b1, "wr1024");
    access(1'b0, 1'b1, 32'd1032, 32'h0, 1'b0, "rd1032");
    access(1'b1, 1'b1, 32'd1028, 32'h0000_0055, 1'b0, "both1028");
    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, "rd1024");
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b1, "rd1028");

    // Back-to-back accesses with both enables held high.
    @(posedge clk); #1;
    write_en = 1'b1; read_en = 1'b1; address = 32'd1036; write_data = 32'h1111_2222;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
      chk($sformatf("b2b_rdy_c%0d", c), 32'(ready), 32'(c % 6 == 5));
      if (c % 6 == 1) chk($sformatf("b2b_st_c%0d", c), 32'(dbg_state), 32'(LOW));
      if (c % 6 == 5) chk($sformatf("b2b_rdata_c%0d", c), read_data, rd_model);
    end
    @(posedge clk); #1;
    write_en = 1'b0; read_en = 1'b0;
    @(negedge clk);
    chk("b2b_end_rdy", 32'(ready), 32'd1);
    chk("b2b_mem_lo", 32'(mem[6]), 32'h2222);
    chk("b2b_mem_hi", 32'(mem[7]), 32'h1111);

    // Reset during the HIGH half of a write.
    @(posedge clk); #1;
    write_en = 1'b1; address = 32'd1040; write_data = 32'hCAFE_F00D;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1; write_en = 1'b0;
    @(negedge clk);
    chk("rstmid_st_high", 32'(dbg_state), 32'(HIGH));
    chk("rstmid_wen_high", 32'(sram_we_n), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    rd_model = 32'd0;
    chk("rstmid_st", 32'(dbg_state), 32'(IDLE));
    chk("rstmid_wen", 32'(sram_we_n), 32'd1);
    chk("rstmid_oe", 32'(sram_dq_oe), 32'd0);
    chk("rstmid_rdata", read_data, rd_model);
    @(posedge clk); #1;
    rst = 1'b0;

    access(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, "rd1024_again");

    // WAIT_CYCLES=1 instance: ready three cycles after the request appears.
    exp_q.push_back({mem1[1], mem1[0]});
    @(posedge clk); #1;
    read_en1 = 1'b1; address1 = 32'd1024;
    @(negedge clk);
    chk("w1_rdy_c0", 32'(ready1), 32'd0);
    @(posedge clk); #1;
    read_en1 = 1'b0;
    @(negedge clk);
    chk("w1_rdy_c1", 32'(ready1), 32'd0);
    chk("w1_addr_c1", 32'(sram_addr1), 32'd0);
    chk("w1_wen_c1", 32'(sram_we_n1), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w1_rdy_c2", 32'(ready1), 32'd0);
    chk("w1_addr_c2", 32'(sram_addr1), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w1_rdy_c3", 32'(ready1), 32'd1);
    chk("w1_rdata", read_data1, exp_q.pop_front());
    chk("w1_wd_done", 32'(sram_wdata1), 32'd0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, giving clock cycles per 16-bit SRAM access (legal range 1..15).
REQ-002 SHALL have parameter BASE_ADDR, default 1024, giving the CPU byte address that maps to SRAM word 0.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port write_en  input  1  MEM-stage store request.
REQ-006 SHALL have port read_en  input  1  MEM-stage load request.
REQ-007 SHALL have port address  input  32  CPU byte address (ALU result from EXE2MEM).
REQ-008 SHALL have port write_data  input  32  store data (reg2 from EXE2MEM).
REQ-009 SHALL have port read_data  output  32  assembled load word.
REQ-010 SHALL have port ready  output  1  access complete / no access pending; the pipeline freezes on ~ready.
REQ-011 SHALL have port sram_addr  output  18  half-word address to the external SRAM.
REQ-012 SHALL have port sram_wdata  output  16  half-word driven onto the SRAM data bus.
REQ-013 SHALL have port sram_rdata  input  16  half-word returned by the SRAM.
REQ-014 SHALL have port sram_we_n  output  1  active-low SRAM write strobe.
REQ-015 SHALL have port sram_dq_oe  output  1  data-bus output enable (1 = controller drives the bus).

Function
REQ-016 SHALL implement FSM states IDLE, LOW, HIGH, DONE.
REQ-017 SHALL move IDLE->LOW when read_en|write_en=1; otherwise remain in IDLE.
REQ-018 SHALL hold LOW and HIGH for exactly WAIT_CYCLES cycles each, using a wait counter cleared on every state entry.
REQ-019 SHALL hold DONE for exactly one cycle, then move to IDLE unconditionally.
REQ-020 SHALL drive ready = (state==DONE) | (state==IDLE & ~read_en & ~write_en); ready is combinational.
REQ-021 SHALL have a latency of 2*WAIT_CYCLES+1 cycles: with WAIT_CYCLES=2 and a request first seen in cycle 0, ready is 0 in cycles 0-4 and 1 in cycle 5.
REQ-022 SHALL compute word = (address - BASE_ADDR) >> 2, truncated modulo 2^17; sram_addr = {word[16:0], 0} in LOW and {word[16:0], 1} in HIGH.
REQ-023 SHALL register the operation type, word address and write_data on the IDLE->LOW transition; later input changes SHALL NOT affect an access in flight.
REQ-024 SHALL give write precedence when read_en and write_en are both 1.
REQ-025 On a write, SHALL drive sram_we_n=0 and sram_dq_oe=1 in LOW and HIGH, with sram_wdata = write_data[15:0] in LOW and write_data[31:16] in HIGH.
REQ-026 On a read, SHALL drive sram_we_n=1 and sram_dq_oe=0, capture sram_rdata into read_data[15:0] on the last LOW cycle, and capture it into read_data[31:16] on the last HIGH cycle.
REQ-027 SHALL hold read_data unchanged from DONE until the next read overwrites it; writes SHALL NOT alter read_data.
REQ-028 SHALL complete an access whose request drops mid-access, without aborting it.
REQ-029 SHALL drive sram_we_n=1, sram_dq_oe=0 and sram_wdata=0 in IDLE and DONE.

Reset
REQ-030 While rst=1 at a clock edge, SHALL set state=IDLE, counter=0, read_data=0 and registered request=none.
REQ-031 Reset asserted mid-access SHALL abort the access and SHALL leave sram_we_n=1 from the next cycle.
REQ-032 After reset, SHALL present ready=1 whenever no request is pending.

Structure
REQ-033 SHALL place the FSM state encoding, the SRAM address/data widths (18/16) and the BASE_ADDR default in the shared CPU package.
REQ-034 SHALL have no sub-module; the wait counter and FSM are implemented inline.

Verification
REQ-035 The bench SHALL write 0xDEADBEEF to address 1024 with WAIT_CYCLES=2 -> sram_addr 0 with wdata 0xBEEF, sram_addr 1 with wdata 0xDEAD, we_n low for 4 cycles, ready high in cycle 5.
REQ-036 The bench SHALL read address 1032 with the SRAM model returning 0x1234 (low) and 0xABCD (high) -> sram_addr 4 then 5, read_data=0xABCD1234 in DONE, ready high in cycle 5.
REQ-037 The bench SHALL assert read_en and write_en together at address 1028 with data 0x00000055 -> a write to sram_addr 2/3 occurs and read_data is unchanged.
REQ-038 The bench SHALL issue back-to-back requests with both enables held high -> ready pulses for exactly one cycle per access and the next access starts in the cycle after DONE.
REQ-039 The bench SHALL assert rst during HIGH of a write -> next cycle state=IDLE, we_n=1, dq_oe=0, read_data=0.
REQ-040 The bench SHALL set WAIT_CYCLES=1 and issue a read at address 1024 -> ready high exactly 3 cycles after the request first appears.
